// File: rtl/jesd_reset_seq.sv
// JESD transceiver clock/reset bring-up and recovery sequencer.
// Define JESD_LOCK_LOSS_RECOVER_EN to auto-restart on lock loss in READY.
module jesd_reset_seq #(
  parameter int CLR_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int SETTLE_CYCLES = 1024,
  parameter int LOCK_FILTER   = 8,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 20
) (
  input  logic       freeclk,
  input  logic       rst,
  input  logic       start,
  input  logic       gt_pll_lock,
  input  logic       gt_reset_done,
  output logic       bufg_clr,
  output logic       gt_pll_reset,
  output logic       gt_dp_reset,
  output logic       core_rst,
  output logic       ready,
  output logic       fail,
  output logic [1:0] retry_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLR       = 3'd1,
    WAIT_LOCK = 3'd2,
    DP_RST    = 3'd3,
    WAIT_DONE = 3'd4,
    SETTLE    = 3'd5,
    READY     = 3'd6,
    FAIL      = 3'd7
  } st_t;

  localparam int FW = $clog2(LOCK_FILTER + 1);
  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [FW-1:0]    FLT_LAST = FW'(LOCK_FILTER - 1);
  localparam logic [FW-1:0]    FLT_MAX  = FW'(LOCK_FILTER);

  st_t              st_q;
  logic [5:0]       outs;
  logic [CNT_W-1:0] timer;
  logic [FW-1:0]    flt;
  logic             lock_m;
  logic             lock_s;
  logic             done_m;
  logic             done_s;
  logic             loss;
  logic             tmo;
  logic             can_retry;
  st_t              rty;

  // {bufg_clr, gt_pll_reset, gt_dp_reset, core_rst, ready, fail}
  function automatic logic [5:0] dec(input st_t s);
    dec = 6'b111100;
    unique case (s)
      IDLE, CLR:         dec = 6'b111100;
      WAIT_LOCK, DP_RST: dec = 6'b001100;
      WAIT_DONE, SETTLE: dec = 6'b000100;
      READY:             dec = 6'b000010;
      FAIL:              dec = 6'b111101;
    endcase
  endfunction

  assign loss      = !lock_s && (flt >= FLT_LAST);
  assign tmo       = (timer >= TO_LAST);
  assign can_retry = {30'd0, retry_cnt} < 32'(MAX_RETRIES);
  assign rty       = can_retry ? CLR : FAIL;

  assign {bufg_clr, gt_pll_reset, gt_dp_reset,
          core_rst, ready, fail} = outs;
  assign state = st_q;

  always_ff @(posedge freeclk) begin
    if (rst) begin
      st_q      <= IDLE;
      outs      <= dec(IDLE);
      retry_cnt <= '0;
      timer     <= '0;
      flt       <= '0;
      lock_m    <= 1'b0;
      lock_s    <= 1'b0;
      done_m    <= 1'b0;
      done_s    <= 1'b0;
    end else begin
      lock_m <= gt_pll_lock;
      lock_s <= lock_m;
      done_m <= gt_reset_done;
      done_s <= done_m;
      if (lock_s)              flt <= '0;
      else if (flt < FLT_MAX)  flt <= flt + 1'b1;
      if (timer != '1) timer <= timer + 1'b1;
      unique case (st_q)
        IDLE, FAIL: if (start) begin
          st_q      <= CLR;
          outs      <= dec(CLR);
          timer     <= '0;
          retry_cnt <= '0;
        end
        CLR: if (timer >= CLR_LAST) begin
          st_q  <= WAIT_LOCK;
          outs  <= dec(WAIT_LOCK);
          timer <= '0;
        end
        // lock wins over a coincident timeout
        WAIT_LOCK: if (lock_s) begin
          st_q  <= DP_RST;
          outs  <= dec(DP_RST);
          timer <= '0;
        end else if (tmo) begin
          st_q  <= rty;
          outs  <= dec(rty);
          timer <= '0;
          if (can_retry) retry_cnt <= retry_cnt + 1'b1;
        end
        DP_RST: begin
          st_q  <= WAIT_DONE;
          outs  <= dec(WAIT_DONE);
          timer <= '0;
        end
        WAIT_DONE: if (done_s) begin
          st_q  <= SETTLE;
          outs  <= dec(SETTLE);
          timer <= '0;
        end else if (tmo || loss) begin
          st_q  <= rty;
          outs  <= dec(rty);
          timer <= '0;
          if (can_retry) retry_cnt <= retry_cnt + 1'b1;
        end
        SETTLE: if (timer >= SET_LAST) begin
          st_q  <= READY;
          outs  <= dec(READY);
          timer <= '0;
        end
        READY: if (start) begin
          st_q      <= CLR;
          outs      <= dec(CLR);
          timer     <= '0;
          retry_cnt <= '0;
        end else if (loss) begin
`ifdef JESD_LOCK_LOSS_RECOVER_EN
          st_q      <= CLR;
          outs      <= dec(CLR);
          retry_cnt <= '0;
`else
          st_q      <= FAIL;
          outs      <= dec(FAIL);
`endif
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jesd_reset_seq.sv
// Directed vector bench for jesd_reset_seq (CLR=4, SETTLE=8,
// TIMEOUT=32, FILTER=8, RETRIES=3).
module tb_jesd_reset_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       lock = 1'b0;
  logic       done = 1'b0;
  logic       bufg_clr;
  logic       gt_pll_reset;
  logic       gt_dp_reset;
  logic       core_rst;
  logic       ready;
  logic       fail;
  logic [1:0] retry_cnt;
  logic [2:0] state;

  always #5 clk = ~clk;

  jesd_reset_seq #(
    .CLR_CYCLES(4), .LOCK_TIMEOUT(32), .SETTLE_CYCLES(8),
    .LOCK_FILTER(8), .MAX_RETRIES(3), .CNT_W(20)
  ) dut (
    .freeclk(clk), .rst(rst), .start(start),
    .gt_pll_lock(lock), .gt_reset_done(done),
    .bufg_clr(bufg_clr), .gt_pll_reset(gt_pll_reset),
    .gt_dp_reset(gt_dp_reset), .core_rst(core_rst),
    .ready(ready), .fail(fail), .retry_cnt(retry_cnt),
    .state(state)
  );

  localparam logic [2:0] S_IDLE = 3'd0, S_CLR = 3'd1, S_WL = 3'd2;
  localparam logic [2:0] S_DP = 3'd3, S_WD = 3'd4, S_SET = 3'd5;
  localparam logic [2:0] S_RDY = 3'd6, S_FAIL = 3'd7;
  // {bufg_clr, gt_pll_reset, gt_dp_reset, core_rst, ready, fail}
  localparam logic [5:0] O_HOLD = 6'b111100, O_WL = 6'b001100;
  localparam logic [5:0] O_WD = 6'b000100, O_RDY = 6'b000010;
  localparam logic [5:0] O_FAIL = 6'b111101;

  typedef struct {
    int         n;
    logic       r, s, l, d;
    logic [2:0] st;
    logic [5:0] o;
    logic [1:0] rc;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   passed = 0;

  task automatic add(input int n, input logic r, input logic s,
                     input logic l, input logic d,
                     input logic [2:0] st, input logic [5:0] o,
                     input logic [1:0] rc);
    vec_t v;
    v.n = n; v.r = r; v.s = s; v.l = l; v.d = d;
    v.st = st; v.o = o; v.rc = rc;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  initial begin
    int cnt;
    // nominal bring-up
    add(1, 1,0,0,0, S_IDLE, O_HOLD, 0);
    add(1, 0,1,0,0, S_CLR,  O_HOLD, 0);
    add(3, 0,0,0,0, S_CLR,  O_HOLD, 0);
    add(10,0,0,0,0, S_WL,   O_WL,   0);
    add(2, 0,0,1,0, S_WL,   O_WL,   0);
    add(1, 0,0,1,0, S_DP,   O_WL,   0);
    add(4, 0,0,1,0, S_WD,   O_WD,   0);
    add(2, 0,0,1,1, S_WD,   O_WD,   0);
    add(8, 0,0,1,1, S_SET,  O_WD,   0);
    add(4, 0,0,1,1, S_RDY,  O_RDY,  0);
    // 7-cycle lock glitch is filtered
    add(7, 0,0,0,1, S_RDY,  O_RDY,  0);
    add(4, 0,0,1,1, S_RDY,  O_RDY,  0);
    // start in READY: full re-run
    add(1, 0,1,1,1, S_CLR,  O_HOLD, 0);
    add(3, 0,0,1,1, S_CLR,  O_HOLD, 0);
    add(1, 0,0,1,1, S_WL,   O_WL,   0);
    add(1, 0,0,1,1, S_DP,   O_WL,   0);
    add(1, 0,0,1,1, S_WD,   O_WD,   0);
    add(8, 0,0,1,1, S_SET,  O_WD,   0);
    add(2, 0,0,1,1, S_RDY,  O_RDY,  0);
    // 9-cycle lock glitch is a lock loss
    add(9, 0,0,0,1, S_RDY,  O_RDY,  0);
`ifdef JESD_LOCK_LOSS_RECOVER_EN
    add(4, 0,0,1,1, S_CLR,  O_HOLD, 0);
`else
    add(4, 0,0,1,1, S_FAIL, O_FAIL, 0);
`endif
    // lock never arrives: 4 attempts then FAIL
    add(1, 1,0,0,0, S_IDLE, O_HOLD, 0);
    add(1, 0,1,0,0, S_CLR,  O_HOLD, 0);
    add(3, 0,0,0,0, S_CLR,  O_HOLD, 0);
    for (int r = 0; r < 4; r++) begin
      if (r > 0) add(4, 0,0,0,0, S_CLR, O_HOLD, 2'(r));
      add(32, 0,0,0,0, S_WL, O_WL, 2'(r));
    end
    add(6, 0,0,0,0, S_FAIL, O_FAIL, 3);
    // start from FAIL; second attempt succeeds
    add(1, 0,1,0,1, S_CLR,  O_HOLD, 0);
    add(3, 0,0,0,1, S_CLR,  O_HOLD, 0);
    add(32,0,0,0,1, S_WL,   O_WL,   0);
    add(4, 0,0,1,1, S_CLR,  O_HOLD, 1);
    add(1, 0,0,1,1, S_WL,   O_WL,   1);
    add(1, 0,0,1,1, S_DP,   O_WL,   1);
    add(1, 0,0,1,1, S_WD,   O_WD,   1);
    add(8, 0,0,1,1, S_SET,  O_WD,   1);
    add(3, 0,0,1,1, S_RDY,  O_RDY,  1);
    // lock and timeout on the same cycle advance
    add(1, 1,0,0,0, S_IDLE, O_HOLD, 0);
    add(1, 0,1,0,0, S_CLR,  O_HOLD, 0);
    add(3, 0,0,0,0, S_CLR,  O_HOLD, 0);
    add(30,0,0,0,0, S_WL,   O_WL,   0);
    add(2, 0,0,1,0, S_WL,   O_WL,   0);
    add(1, 0,0,1,0, S_DP,   O_WL,   0);
    // rst (with start) during WAIT_DONE
    add(2, 0,0,1,0, S_WD,   O_WD,   0);
    add(1, 1,1,1,0, S_IDLE, O_HOLD, 0);
    add(3, 0,0,1,0, S_IDLE, O_HOLD, 0);

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        rst = tbl[i].r; start = tbl[i].s;
        lock = tbl[i].l; done = tbl[i].d;
        @(posedge clk);
        #1;
        chk($sformatf("row%0d.%0d", i, k),
            32'({state, bufg_clr, gt_pll_reset, gt_dp_reset,
                 core_rst, ready, fail, retry_cnt}),
            32'({tbl[i].st, tbl[i].o, tbl[i].rc}));
      end
    end

    // start-to-ready latency with lock and done already present
    rst = 1'b1; start = 1'b0; lock = 1'b1; done = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b1;
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      start = 1'b0;
      cnt++;
    end while (!ready && cnt < 200);
    chk("latency", 32'(cnt), 32'd16);
    chk("lat_out", 32'({ready, core_rst, fail, retry_cnt}),
        32'(5'b10000));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
